// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle-detection sequencer for one Boolean GRN run: measures transient
// length mu and attractor period lambda from a dual-copy node array.
module grn_attractor_ctrl #(
  parameter int NODES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NODES-1:0] init_vec,
  input  logic [CNT_W-1:0] max_steps,
  input  logic [NODES-1:0] s0_vec,
  input  logic [NODES-1:0] s1_vec,
  output logic             reset_nos,
  output logic [NODES-1:0] init_state,
  output logic             start_s0,
  output logic             start_s1,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] mu,
  output logic [CNT_W-1:0] lambda,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_MEET, S_LAM, S_RELOAD, S_AHEAD, S_MU_A, S_MU_B, S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, max_q, mu_q, lambda_q;
  logic [NODES-1:0] init_q;
  logic             busy_q, done_q, timeout_q;

  logic             eq, hit, lam_hit, over;
  logic [CNT_W:0]   cnt_inc;

  // Increment is one bit wider so the budget comparison never sees a wrap.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign over    = cnt_inc > {1'b0, max_q};
  assign eq      = (s0_vec == s1_vec);
  assign hit     = eq && (cnt_q >= CNT_W'(2)) && !cnt_q[0];
  assign lam_hit = eq && (cnt_q != '0);

  assign reset_nos = (state_q == S_LOAD) || (state_q == S_RELOAD);
  assign start_s0  = ((state_q == S_MEET) && !hit) ||
                     ((state_q == S_MU_A) && !eq) ||
                     (state_q == S_MU_B);
  assign start_s1  = ((state_q == S_MEET) && !hit) ||
                     ((state_q == S_LAM) && !lam_hit) ||
                     (state_q == S_AHEAD) ||
                     ((state_q == S_MU_A) && !eq);

  assign init_state = init_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign mu         = mu_q;
  assign lambda     = lambda_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      max_q     <= '0;
      mu_q      <= '0;
      lambda_q  <= '0;
      init_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            init_q    <= init_vec;
            max_q     <= max_steps;
            cnt_q     <= '0;
            mu_q      <= '0;
            lambda_q  <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: state_q <= S_MEET;
        S_MEET: begin
          if (hit) begin
            cnt_q   <= '0;
            state_q <= S_LAM;
          end else if (over) begin
            timeout_q <= 1'b1;
            mu_q      <= '0;
            lambda_q  <= '0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        S_LAM: begin
          if (lam_hit) begin
            lambda_q <= cnt_q;
            state_q  <= S_RELOAD;
          end else if (over) begin
            timeout_q <= 1'b1;
            mu_q      <= '0;
            lambda_q  <= '0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        S_RELOAD: begin
          cnt_q   <= '0;
          state_q <= S_AHEAD;
        end
        S_AHEAD: begin
          // Hare gets a lambda-step head start; last push leaves with cnt cleared.
          if (cnt_inc == {1'b0, lambda_q}) begin
            cnt_q   <= '0;
            state_q <= S_MU_A;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        S_MU_A: begin
          if (eq) begin
            mu_q    <= cnt_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_MU_B;
          end
        end
        S_MU_B: begin
          if (over) begin
            timeout_q <= 1'b1;
            mu_q      <= '0;
            lambda_q  <= '0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q   <= cnt_inc[CNT_W-1:0];
            state_q <= S_MU_A;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: behavioural dual-copy node array plus a
// sequence-based reference for mu, lambda, timeout and latency.
module tb_grn_attractor_ctrl;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int W  = 33;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  init_vec = '0;
  logic [CW-1:0] max_steps = '0;
  logic [N-1:0]  s0_vec = '0, s1_vec = '0;
  logic          pass_q = 1'b1;
  logic          reset_nos, start_s0, start_s1, busy, done, timeout;
  logic [N-1:0]  init_state;
  logic [CW-1:0] mu, lambda;
  logic [3:0]    dbg_state;

  logic [N-1:0]  fmap [16];
  logic [W-1:0]  exp_q [$];
  int            n_checks = 0, n_err = 0;
  logic [CW-1:0] last_mu = '0, last_lam = '0;

  // clock / reset block
  always #5 clk = ~clk;

  grn_attractor_ctrl #(.NODES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
    .max_steps(max_steps), .s0_vec(s0_vec), .s1_vec(s1_vec),
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0),
    .start_s1(start_s1), .busy(busy), .done(done), .timeout(timeout),
    .mu(mu), .lambda(lambda), .dbg_state(dbg_state)
  );

  // Node array: copy 1 steps on every start_s1, copy 0 only on odd start_s0.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      pass_q <= 1'b1;
    end else begin
      if (start_s1) s1_vec <= fmap[s1_vec];
      if (start_s0) begin
        if (pass_q) s0_vec <= fmap[s0_vec];
        pass_q <= ~pass_q;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Trajectory x_i = F^i(x): first repeat gives mu/lambda, x_k == x_2k gives the meet.
  function automatic void ref_model(input logic [N-1:0] x, input logic [CW-1:0] ms,
                                    output bit to, output int emu, output int elam,
                                    output int elat);
    int seq [64];
    int k, m;
    bit found;
    seq[0] = int'(x);
    for (int i = 1; i < 64; i++) seq[i] = int'(fmap[seq[i-1][N-1:0]]);
    found = 0; emu = 0; elam = 0;
    for (int j = 1; j < 64; j++)
      for (int i = 0; i < j; i++)
        if (!found && seq[i] == seq[j]) begin found = 1; emu = i; elam = j - i; end
    k = 0;
    for (int kk = 1; kk < 32; kk++) if (k == 0 && seq[kk] == seq[2*kk]) k = kk;
    m = 2 * k;
    to = (m > int'(ms));
    if (to) begin
      emu = 0; elam = 0;
      elat = 1 + int'(ms) + 1;
    end else begin
      elat = 1 + (m + 1) + (elam + 1) + 1 + elam + (2 * emu + 1);
    end
  endfunction

  task automatic run(input logic [N-1:0] iv, input logic [CW-1:0] ms,
                     input int poke_at, input int abort_at);
    bit to, seg;
    int emu, elam, elat, n, rn, ahead, excl;
    logic [W-1:0] exp_w, got_w;
    ref_model(iv, ms, to, emu, elam, elat);
    exp_q.push_back({to, elam[15:0], emu[15:0]});
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("done_pulse", done, 0);
    check("held_mu", mu, last_mu);
    check("held_lambda", lambda, last_lam);
    start = 1'b1; init_vec = iv; max_steps = ms;
    @(negedge clk);
    start = 1'b0; init_vec = N'($urandom); max_steps = CW'($urandom);
    n = 0; rn = 0; ahead = 0; excl = 0; seg = 0;
    while (!done && n < 2000) begin
      n++;
      if (n == 1) begin
        check("accept_reset_nos", reset_nos, 1);
        check("accept_busy", busy, 1);
        check("accept_init", init_state, iv);
      end
      if (reset_nos) begin
        rn++;
        if (rn == 2) seg = 1;
      end else if (seg) begin
        if (start_s1 && !start_s0) ahead++;
        else seg = 0;
      end
      if (reset_nos && start_s0) excl++;
      if (poke_at > 0 && n == poke_at) begin start = 1'b1; init_vec = ~iv; end
      if (poke_at > 0 && n == poke_at + 1) begin
        start = 1'b0;
        check("poke_init_state", init_state, iv);
        check("poke_busy", busy, 1);
      end
      if (n == abort_at) begin
        #2 rst = 1'b0;
        #1 check("async_reset_outs",
                 {reset_nos, start_s0, start_s1, busy, done, timeout, mu, lambda, init_state}, 0);
        @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_front());
        last_mu = '0; last_lam = '0;
        return;
      end
      @(negedge clk);
    end
    exp_w = exp_q.pop_front();
    if (!done) begin
      check("done_wait", 0, 1);
      return;
    end
    got_w = {timeout, lambda, mu};
    check("result", got_w, exp_w);
    check("latency", n, elat);
    check("reset_nos_count", rn, to ? 1 : 2);
    if (!to) check("ahead_len", ahead, elam);
    check("s0_reset_excl", excl, 0);
    last_mu = mu; last_lam = lambda;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fmap[i] = N'(i);
    #23;
    check("reset_outs",
          {reset_nos, start_s0, start_s1, busy, done, timeout, mu, lambda, init_state}, 0);
    rst = 1'b1;

    run(4'h5, 16'd100, 0, 0);                      // fixed point
    for (int i = 0; i < 16; i++) fmap[i] = '0;     // back-to-back with chain map
    fmap[1] = 4'h2; fmap[2] = 4'h3; fmap[3] = 4'h4; fmap[4] = 4'h5;
    fmap[5] = 4'h6; fmap[6] = 4'h7; fmap[7] = 4'h4;
    run(4'h1, 16'd100, 0, 0);
    run(4'h1, 16'd3, 0, 0);                        // timeout
    run(4'h1, 16'd0, 0, 0);                        // zero budget
    run(4'h1, 16'd100, 4, 0);                      // start ignored while busy
    run(4'h1, 16'd100, 0, 12);                     // async reset in LAM
    run(4'h1, 16'd100, 0, 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++) fmap[i] = N'($urandom_range(0, 15));
      run(N'($urandom_range(0, 15)), CW'($urandom_range(0, 40)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
